// File: rtl/rom_region_loader.sv
// rom_region_loader: filters the ioctl download stream by index, decodes each
// accepted write into one of NUM_REGIONS ROM regions and emits a registered
// one-hot write strobe with a region-local address. Tracks per-region fill,
// total accepted bytes, completion and decode errors.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add region_sum, a
// per-region modulo-256 sum of accepted bytes.
module rom_region_loader #(
    parameter int                            NUM_REGIONS = 16,
    parameter int                            ADDR_W      = 25,
    parameter int                            REGION_AW   = 16,
    parameter logic [7:0]                    INDEX       = 8'd0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
    parameter logic [NUM_REGIONS*5-1:0]      REGION_LOG2 = '0
) (
    input  logic                   clk_49m,
    input  logic                   reset,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [7:0]             ioctl_data,
    input  logic                   ioctl_wr,
    output logic [NUM_REGIONS-1:0] rom_we,
    output logic [REGION_AW-1:0]   rom_addr,
    output logic [7:0]             rom_data,
    output logic [NUM_REGIONS-1:0] region_full,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   load_error,
    output logic [ADDR_W-1:0]      byte_count
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [NUM_REGIONS*8-1:0] region_sum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t                 state_q;
    logic                   arm_q;      // download was seen low since reset / last start
    logic [NUM_REGIONS-1:0] rom_we_q;
    logic [REGION_AW-1:0]   rom_addr_q;
    logic [7:0]             rom_data_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [ADDR_W-1:0]      bcnt_q;

    logic                   enter;
    logic                   wr_acc;
    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0][REGION_AW-1:0] off;
    logic [NUM_REGIONS-1:0] sel;
    logic [REGION_AW-1:0]   sel_off;
    logic                   found;

    // A download starts only on a fresh rise of ioctl_download with our index.
    assign enter  = (state_q == S_IDLE) && ioctl_download && arm_q && (ioctl_index == INDEX);
    assign wr_acc = (state_q == S_LOAD) && ioctl_wr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            localparam logic [ADDR_W:0]    LO   = {1'b0, REGION_BASE[gi*ADDR_W +: ADDR_W]};
            localparam logic [ADDR_W:0]    HI   = LO + ((ADDR_W+1)'(1) << REGION_LOG2[gi*5 +: 5]);
            localparam logic [REGION_AW:0] SIZE = (REGION_AW+1)'(1) << REGION_LOG2[gi*5 +: 5];

            logic [ADDR_W:0]    a_ext;
            logic [REGION_AW:0] cnt_q;

            assign a_ext     = {1'b0, ioctl_addr};
            assign hit[gi]   = (a_ext >= LO) && (a_ext < HI);
            // Offset fits in REGION_AW bits whenever the region hits.
            assign off[gi]   = ioctl_addr[REGION_AW-1:0] - LO[REGION_AW-1:0];
            assign region_full[gi] = (cnt_q == SIZE);

            // Per-region write counter, saturating at the region size.
            always_ff @(posedge clk_49m) begin
                if (!reset)
                    cnt_q <= '0;
                else if (enter)
                    cnt_q <= '0;
                else if (wr_acc && sel[gi] && cnt_q != SIZE)
                    cnt_q <= cnt_q + (REGION_AW+1)'(1);
            end

`ifdef ROM_LOADER_CHECKSUM_EN
            logic [7:0] sum_q;
            // Byte sum trails the write strobe by one cycle.
            always_ff @(posedge clk_49m) begin
                if (!reset)
                    sum_q <= '0;
                else if (enter)
                    sum_q <= '0;
                else if (rom_we_q[gi])
                    sum_q <= sum_q + rom_data_q;
            end
            assign region_sum[gi*8 +: 8] = sum_q;
`endif
        end
    endgenerate

    // Lowest-index hit wins so overlapping regions still give a one-hot strobe.
    always_comb begin
        sel     = '0;
        sel_off = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (hit[i] && !found) begin
                sel[i]  = 1'b1;
                sel_off = off[i];
                found   = 1'b1;
            end
        end
    end

    // Load FSM with registered strobe, status and byte counter.
    always_ff @(posedge clk_49m) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            arm_q      <= 1'b0;
            rom_we_q   <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            rom_we_q <= '0;
            done_q   <= 1'b0;
            if (!ioctl_download)
                arm_q <= 1'b1;
            else if (state_q == S_IDLE)
                arm_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enter) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        bcnt_q  <= '0;
                    end
                end
                S_LOAD: begin
                    if (ioctl_wr) begin
                        if (found) begin
                            rom_we_q   <= sel;
                            rom_addr_q <= sel_off;
                            rom_data_q <= ioctl_data;
                            if (bcnt_q != '1)
                                bcnt_q <= bcnt_q + ADDR_W'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    if (!ioctl_download) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign byte_count = bcnt_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// Randomized + directed bench for rom_region_loader against a transaction-level
// reference model (region lookup table, per-region counts, download state).
module tb_rom_region_loader;
    localparam int NR  = 4;
    localparam int AW  = 16;
    localparam int RAW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          dl = 1'b0;
    logic [7:0]    idx = 8'd0;
    logic [AW-1:0] a = '0;
    logic [7:0]    d = 8'd0;
    logic          wr = 1'b0;
    logic [NR-1:0]  rom_we, region_full;
    logic [RAW-1:0] rom_addr;
    logic [7:0]     rom_data;
    logic           load_busy, load_done, load_error;
    logic [AW-1:0]  byte_count;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [NR*8-1:0] region_sum;
`endif

    rom_region_loader #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .REGION_AW(RAW), .INDEX(8'd0),
        .REGION_BASE(64'h4000_0800_1000_0000),
        .REGION_LOG2({5'd4, 5'd10, 5'd12, 5'd12})
    ) dut (
        .clk_49m(clk), .reset(reset_n), .ioctl_download(dl), .ioctl_index(idx),
        .ioctl_addr(a), .ioctl_data(d), .ioctl_wr(wr),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .region_full(region_full), .load_busy(load_busy), .load_done(load_done),
        .load_error(load_error), .byte_count(byte_count)
`ifdef ROM_LOADER_CHECKSUM_EN
        , .region_sum(region_sum)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int base[NR] = '{'h0000, 'h1000, 'h0800, 'h4000};
    int lg[NR]   = '{12, 12, 10, 4};

    // reference model state
    bit             m_load, m_done, m_armed, m_err, m_busy, m_dpulse;
    int             m_cnt[NR];
    int             m_bcnt;
    logic [RAW-1:0] m_addr;
    logic [7:0]     m_data;
    logic [NR-1:0]  m_we;
    logic [7:0]     m_sum[NR];
    int             pend_r;
    logic [7:0]     pend_d;
    int n_we = 0, n_done = 0, n_busy = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int find(input int ad);
        for (int i = 0; i < NR; i++)
            if (ad >= base[i] && ad < base[i] + (1 << lg[i])) return i;
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit dl_i, input logic [7:0] idx_i,
                              input bit wr_i, input int a_i, input logic [7:0] d_i);
        bit idle;
        int r;
        if (rst) begin
            m_load = 0; m_done = 0; m_armed = 0; m_err = 0; m_busy = 0; m_dpulse = 0;
            m_bcnt = 0; m_addr = '0; m_data = '0; m_we = '0; pend_r = -1;
            for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; m_sum[i] = 8'd0; end
        end else begin
            if (pend_r >= 0) m_sum[pend_r] = m_sum[pend_r] + pend_d;
            pend_r = -1;
            idle = !m_load && !m_done;
            m_we = '0;
            m_dpulse = 0;
            if (m_load) begin
                if (wr_i) begin
                    r = find(a_i);
                    if (r >= 0) begin
                        m_we[r] = 1'b1;
                        m_addr = RAW'(a_i - base[r]);
                        m_data = d_i;
                        if (m_cnt[r] < (1 << lg[r])) m_cnt[r]++;
                        if (m_bcnt < 'hFFFF) m_bcnt++;
                        pend_r = r; pend_d = d_i;
                    end else m_err = 1;
                end
                if (!dl_i) begin m_load = 0; m_done = 1; m_dpulse = 1; end
            end else if (m_done) begin
                m_done = 0;
            end else if (dl_i && m_armed && idx_i == 8'd0) begin
                m_load = 1; m_err = 0; m_bcnt = 0;
                for (int i = 0; i < NR; i++) begin m_cnt[i] = 0; m_sum[i] = 8'd0; end
            end
            if (!dl_i) m_armed = 1;
            else if (idle) m_armed = 0;
            m_busy = m_load;
        end
    endtask

    // One clock: drive, advance model, sample after the edge and compare.
    task automatic step(input bit rst, input bit dl_i, input logic [7:0] idx_i,
                        input bit wr_i, input int a_i, input logic [7:0] d_i);
        logic [NR-1:0] ef;
        @(negedge clk);
        reset_n = !rst; dl = dl_i; idx = idx_i; wr = wr_i; a = AW'(a_i); d = d_i;
        model_step(rst, dl_i, idx_i, wr_i, a_i, d_i);
        @(posedge clk); #1;
        if (rom_we != '0) n_we++;
        if (load_done) n_done++;
        if (load_busy) n_busy++;
        for (int i = 0; i < NR; i++) ef[i] = (m_cnt[i] == (1 << lg[i]));
        chk("rom_we", rom_we, m_we);
        chk("rom_addr", rom_addr, m_addr);
        chk("rom_data", rom_data, m_data);
        chk("busy", load_busy, m_busy);
        chk("done", load_done, m_dpulse);
        chk("error", load_error, m_err);
        chk("byte_count", byte_count, m_bcnt);
        chk("region_full", region_full, ef);
`ifdef ROM_LOADER_CHECKSUM_EN
        for (int i = 0; i < NR; i++) chk("region_sum", region_sum[i*8 +: 8], m_sum[i]);
`endif
    endtask

    function automatic int pick();
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 'h1FFF);
            1: return 'h4000 + $urandom_range(0, 31);
            2: return $urandom_range(0, 'hFFFF);
            default: return 'h0800 + $urandom_range(0, 'h3FF);
        endcase
    endfunction

    initial begin
        int we0, dn0, bz0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_we", rom_we, 0);
        chk("rst_bcnt", byte_count, 0);
        step(0, 0, 0, 0, 0, 0);

        // full 0x2000-byte download over regions 0 and 1, last write on falling edge
        dn0 = n_done; we0 = n_we;
        step(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 'h1FFF; k++) begin
            step(0, 1, 0, 1, k, 8'($urandom));
            if (k == 'h1000) chk("t1_wrap", {rom_we, rom_addr}, {4'b0010, 12'h000});
        end
        step(0, 0, 0, 1, 'h1FFF, 8'($urandom));
        step(0, 0, 0, 0, 0, 0);
        chk("t1_full", region_full, 4'b0011);
        chk("t1_bcnt", byte_count, 16'h2000);
        chk("t1_we", n_we - we0, 'h2000);
        chk("t1_done", n_done - dn0, 1);

        // wrong index: ignored entirely
        we0 = n_we; dn0 = n_done; bz0 = n_busy;
        for (int k = 0; k < 12; k++) step(0, 1, 8'd1, 1, k, 8'($urandom));
        step(0, 0, 8'd1, 0, 0, 0);
        step(0, 0, 8'd1, 0, 0, 0);
        chk("t2_we", n_we - we0, 0);
        chk("t2_busy", n_busy - bz0, 0);
        chk("t2_done", n_done - dn0, 0);

        // overlap priority, out-of-region error, region-3 saturation
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 'h0900, 8'h5A);
        chk("t4_ovl", {rom_we, rom_addr}, {4'b0001, 12'h900});
        step(0, 1, 0, 1, 'h3000, 8'h11);
        chk("t3_we", rom_we, 0);
        chk("t3_err", load_error, 1);
        for (int k = 0; k < 20; k++) step(0, 1, 0, 1, 'h4000 + (k % 16), 8'($urandom));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_err_hold", load_error, 1);
        chk("t3_full3", region_full[3], 1);
        chk("t3_bcnt", byte_count, 21);

        // reset in the middle of a download
        step(0, 1, 0, 0, 0, 0);
        chk("t5_err_clr", load_error, 0);
        for (int k = 0; k < 'h400; k++) step(0, 1, 0, 1, k, 8'($urandom));
        step(1, 1, 0, 1, 'h400, 8'h77);
        chk("t5_zero", {rom_we, rom_addr, rom_data, region_full, load_busy, load_error, byte_count}, 0);
        we0 = n_we;
        for (int k = 0; k < 10; k++) step(0, 1, 0, 1, 'h401 + k, 8'($urandom));
        chk("t5_ignored", n_we - we0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t5_fresh", load_busy, 1);

        // checksum: 0xFF + 0x02 into region 0
        step(0, 1, 0, 1, 'h10, 8'hFF);
        step(0, 1, 0, 1, 'h11, 8'h02);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
        chk("t6_sum", region_sum[7:0], 8'h01);
`endif

        // randomized sessions
        for (int s = 0; s < 150; s++) begin
            int len = $urandom_range(3, 40);
            logic [7:0] ix = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
            int gap = $urandom_range(0, 3);
            for (int k = 0; k < len; k++)
                step(($urandom_range(0, 199) == 0), 1, ix, 1'($urandom_range(0, 1)), pick(), 8'($urandom));
            for (int k = 0; k <= gap; k++)
                step(0, 0, ix, 1'($urandom_range(0, 1)), pick(), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_region_loader.md
# rom_region_loader

Parametrised ROM download router for the arcade cores. It takes the MiSTer ioctl download stream and filters it by ioctl index. It decodes each write into one of NUM_REGIONS ROM regions and drives a registered one-hot write strobe with a region-local address. It also tracks per-region fill progress and reports download completion and errors. It sits between the top-level ioctl inputs and the board-level ROM instances, replacing hand-written address selectors and index filters.

## Interface
- NUM_REGIONS, 16, number of ROM regions (1–32)
- ADDR_W, 25, ioctl address width
- REGION_AW, 16, width of region-local address output
- INDEX, 8'd0, ioctl index this instance accepts
- REGION_BASE, 0, packed NUM_REGIONS×ADDR_W byte base addresses; region i occupies bits [i*ADDR_W +: ADDR_W]
- REGION_LOG2, 0, packed NUM_REGIONS×5 size exponents; region i size = 2^REGION_LOG2[i], ≤ 2^REGION_AW
- clk_49m  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  download index
- ioctl_addr  in  ADDR_W  byte address
- ioctl_data  in  8  byte data
- ioctl_wr  in  1  one-cycle write strobe
- rom_we  out  NUM_REGIONS  one-hot registered write enable
- rom_addr  out  REGION_AW  region-local address (ioctl_addr − base)
- rom_data  out  8  registered write data
- region_full  out  NUM_REGIONS  region i has received 2^REGION_LOG2[i] writes
- load_busy  out  1  FSM in LOAD
- load_done  out  1  one-cycle pulse at end of accepted download
- load_error  out  1  sticky: accepted write hit no region
- byte_count  out  ADDR_W  accepted in-region writes this download, saturating

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE → LOAD: ioctl_download=1 and ioctl_index==INDEX. On entry, clear region_full, byte counters, load_error and byte_count.
- LOAD → DONE: ioctl_download falls. Assert load_done for exactly one cycle.
- DONE → IDLE: next cycle. DONE → LOAD also goes through IDLE, so a re-download always restarts.
- In IDLE, a download with a non-matching index is ignored entirely. The FSM stays in IDLE until that download ends.
- A write is accepted only in LOAD with ioctl_wr=1. ioctl_wr outside LOAD is ignored.
- Decode: region i hits when REGION_BASE[i] ≤ ioctl_addr < REGION_BASE[i]+2^REGION_LOG2[i]. Overlapping hits are resolved to the lowest i, so rom_we stays strictly one-hot.
- A hit increments that region's counter. The counter is REGION_AW+1 bits wide and saturates at the region size. region_full[i] is set when the counter reaches size. Rewrites of an already-written address still count.
- No hit: rom_we stays all-zero and load_error is set. byte_count is unchanged.
- Outputs persist after DONE (region_full, load_error, byte_count) until the next accepted download or reset.

## Timing
- Write latency is 1 cycle. An accepted ioctl_wr in cycle n gives rom_we/rom_addr/rom_data valid in cycle n+1, with rom_we high for exactly one cycle.
- rom_addr and rom_data hold their last value when rom_we=0.
- Back-to-back ioctl_wr on consecutive cycles is supported at full rate.
- ioctl_wr coincident with the ioctl_download falling edge is still accepted if the FSM is in LOAD that cycle.
- Reset values: FSM=IDLE, rom_we=0, rom_addr=0, rom_data=0, region_full=0, load_busy=0, load_done=0, load_error=0, byte_count=0.
- Reset asserted mid-download returns everything to reset values on the next clock. After release, a still-high ioctl_download does not re-enter LOAD. The FSM waits for ioctl_download=0, then a new rising download.
- byte_count saturates at all-ones.

## Configuration
- ROM_LOADER_CHECKSUM_EN defined: adds output region_sum (NUM_REGIONS×8). It is an 8-bit modulo-256 additive sum of accepted bytes per region, cleared on LOAD entry and updated one cycle after the matching rom_we.
- Not defined: the port and its adders are absent; all other behaviour is identical.

## Test plan
- NUM_REGIONS=2, bases 0x0000/0x1000, LOG2=12/12, INDEX=0. Download index 0 writing 0x2000 bytes → 0x1000 rom_we[0] pulses, then 0x1000 rom_we[1] pulses. rom_addr wraps 0x0FFF→0x0000 at the boundary. region_full=2'b11, byte_count=0x2000, one load_done pulse.
- Download with index 1 into INDEX=0 instance → rom_we never asserts, load_busy=0, no load_done.
- Write at 0x3000 (no region) → rom_we=0, load_error=1 until the next accepted download starts.
- Overlap bases 0x0000/0x0800, write 0x0900 → only rom_we[0] asserts, rom_addr=0x0900.
- Reset low at byte 0x0400 with ioctl_download held high → all outputs zero. After reset release, the same ongoing download is not accepted; a fresh download is.
- With ROM_LOADER_CHECKSUM_EN, bytes 0xFF,0x02 to region 0 → region_sum[7:0]=0x01.
